core_mem_arbiter: RTL and testbench
===================================

Name: core_mem_arbiter

Overview:
- Shares one downstream cache/memory request bus between two upstream requesters: port 0 is instruction fetch, port 1 is data (Memory-stage loads, writeback stores).
- Round-robin arbitration, one transaction in flight at a time.
- Forwards multi-beat requests downstream and routes multi-beat responses back to the granted port.
- Sits between the core-side cache interfaces and the shared bus.

Parameters:
ADDR_W, 64, width of req/resp data beats
TAG_W, 13, reqtag width; tag bit 0 (MSB, [0:TAG_W-1] numbering) is the direction: 0 = READ, 1 = WRITE
RD_BEATS, 8, response beats returned for a read
WR_BEATS, 8, write-data beats following a write address beat; a write returns exactly 1 response beat

Ports:
clk  in  1  clock; all state updates on posedge
reset  in  1  asynchronous, active-low reset (asserted when 0)
p0_reqcyc / p1_reqcyc  in  1  port request valid; held until port reqack
p0_req / p1_req  in  ADDR_W  address beat, then write-data beats
p0_reqtag / p1_reqtag  in  TAG_W  transaction tag; stable for the whole request phase
p0_reqack / p1_reqack  out  1  beat accepted; copy of bus_reqack while that port is granted
p0_respcyc / p1_respcyc  out  1  response beat valid for that port
p0_resp / p1_resp  out  ADDR_W  response data
p0_respack / p1_respack  in  1  port accepts response beat
bus_reqcyc  out  1  downstream request valid
bus_req  out  ADDR_W  downstream request beat
bus_reqtag  out  TAG_W  downstream tag
bus_reqack  in  1  downstream beat accepted
bus_respcyc  in  1  downstream response beat valid
bus_resp  in  ADDR_W  downstream response data
bus_respack  out  1  response beat accepted
busy  out  1  state != IDLE
grant_id  out  1  currently or last granted port

Behaviour:
- States: IDLE, REQ, RESP.
- Registers: state, grant_id, last_grant, beat counter (log2 of max(RD_BEATS, WR_BEATS+1) plus 1 bits), is_write.

Reset (reset == 0, asynchronous):
- state = IDLE, grant_id = 0, last_grant = 1, counter = 0, is_write = 0.
- All port/bus outputs 0.
- Reset mid-transaction drops the transaction silently; a port must reissue after reset.

IDLE:
- Arbitration samples p0_reqcyc and p1_reqcyc.
- Only one asserted: grant that port.
- Both asserted: grant the port that is not last_grant.
- On grant: grant_id <= winner, last_grant <= winner, is_write <= reqtag[0], counter <= 0, state <= REQ.
- No bus outputs asserted while in IDLE, so arbitration costs one cycle of latency.

REQ:
- bus_reqcyc/bus_req/bus_reqtag are combinational pass-throughs of the granted port.
- Granted port's reqack = bus_reqack; the other port's reqack = 0.
- Each cycle with bus_reqcyc && bus_reqack counts one beat.
- Reads: after 1 beat -> RESP, counter <= 0.
- Writes: after 1 + WR_BEATS beats -> RESP, counter <= 0.
- A requester dropping reqcyc mid-phase is a protocol error; the arbiter keeps waiting and does not recover.

RESP:
- Granted port's respcyc = bus_respcyc and resp = bus_resp.
- bus_respack = granted port's respack.
- Each bus_respcyc && bus_respack counts one beat.
- Reads complete after RD_BEATS beats, writes after 1 beat; on completion state <= IDLE.
- Non-granted port sees respcyc = 0 at all times.
- bus_respcyc in IDLE or REQ is ignored: bus_respack = 0, nothing is forwarded.

Boundary conditions:
- A new request arriving during REQ/RESP waits; it is arbitrated in the first IDLE cycle after completion.
- The final response beat and a new request in the same cycle: the new grant happens the next cycle (IDLE), never back-to-back.
- The same port requesting continuously while the other is idle is re-granted every transaction.

Test Plan:
- Reset release, p0 read at address 0x1000, tag bit0=0:
  - bus_reqcyc rises one cycle after p0_reqcyc, bus_req=0x1000.
  - After reqack, exactly 8 response beats appear on p0 only; busy returns to 0.
- p0 and p1 both request in the same cycle from reset: p0 is granted first (last_grant=1); p1 is granted in the IDLE cycle after p0's 8th response beat.
- Both ports request continuously for 4 transactions: grant_id sequence is 0,1,0,1.
- p1 write (tag bit0=1) with bus_reqack asserted every other cycle:
  - 9 beats are accepted in total.
  - A single response beat is routed to p1 and p0 sees no respcyc.
- Stray bus_respcyc while IDLE: bus_respack stays 0 and no port respcyc is asserted.
- reset driven to 0 at response beat 3 of a read: all outputs 0 immediately (asynchronously); after release, state is IDLE and a new p1 request is granted.

Source files
------------

// File: rtl/core_mem_arbiter.sv
// core_mem_arbiter: round-robin arbiter that shares one multi-beat cache/memory
// request bus between instruction fetch (port 0) and data (port 1). One
// transaction is in flight at a time; responses are routed back to the winner.
module core_mem_arbiter #(
   parameter int ADDR_W   = 64,
   parameter int TAG_W    = 13,
   parameter int RD_BEATS = 8,
   parameter int WR_BEATS = 8
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              p0_reqcyc,
   input  logic [ADDR_W-1:0] p0_req,
   input  logic [0:TAG_W-1]  p0_reqtag,
   output logic              p0_reqack,
   output logic              p0_respcyc,
   output logic [ADDR_W-1:0] p0_resp,
   input  logic              p0_respack,
   input  logic              p1_reqcyc,
   input  logic [ADDR_W-1:0] p1_req,
   input  logic [0:TAG_W-1]  p1_reqtag,
   output logic              p1_reqack,
   output logic              p1_respcyc,
   output logic [ADDR_W-1:0] p1_resp,
   input  logic              p1_respack,
   output logic              bus_reqcyc,
   output logic [ADDR_W-1:0] bus_req,
   output logic [0:TAG_W-1]  bus_reqtag,
   input  logic              bus_reqack,
   input  logic              bus_respcyc,
   input  logic [ADDR_W-1:0] bus_resp,
   output logic              bus_respack,
   output logic              busy,
   output logic              grant_id
);

   localparam int MAX_BEATS = (RD_BEATS > WR_BEATS + 1) ? RD_BEATS : WR_BEATS + 1;
   localparam int CNT_W     = $clog2(MAX_BEATS) + 1;
   // A write request is one address beat plus WR_BEATS data beats, so the
   // last request beat of a write is seen with the counter at WR_BEATS.
   localparam logic [CNT_W-1:0] REQ_LAST_WR  = CNT_W'(WR_BEATS);
   localparam logic [CNT_W-1:0] RESP_LAST_RD = CNT_W'(RD_BEATS - 1);

   typedef enum logic [1:0] {IDLE, REQ, RESP} state_t;

   state_t            state;
   logic              last_grant;
   logic              is_write;
   logic [CNT_W-1:0]  count;

   logic              any_req;
   logic              winner;
   logic              win_write;
   logic              g_reqcyc;
   logic [ADDR_W-1:0] g_req;
   logic [0:TAG_W-1]  g_reqtag;
   logic              g_respack;
   logic              in_req;
   logic              in_resp;
   logic              req_beat;
   logic              resp_beat;
   logic              req_last;
   logic              resp_last;

   // Round-robin pick: a lone requester wins, a tie goes to the port not served last.
   always_comb begin
      any_req = p0_reqcyc | p1_reqcyc;
      if (p0_reqcyc && p1_reqcyc) begin
         winner = ~last_grant;
      end else if (p1_reqcyc) begin
         winner = 1'b1;
      end else begin
         winner = 1'b0;
      end
      win_write = winner ? p1_reqtag[0] : p0_reqtag[0];
   end

   // Steer the granted port onto the bus; outside REQ/RESP everything is held at 0
   // so arbitration and stray bus responses never leak through.
   always_comb begin
      g_reqcyc  = grant_id ? p1_reqcyc  : p0_reqcyc;
      g_req     = grant_id ? p1_req     : p0_req;
      g_reqtag  = grant_id ? p1_reqtag  : p0_reqtag;
      g_respack = grant_id ? p1_respack : p0_respack;
      in_req    = (state == REQ);
      in_resp   = (state == RESP);

      bus_reqcyc  = in_req & g_reqcyc;
      bus_req     = in_req ? g_req : '0;
      bus_reqtag  = in_req ? g_reqtag : '0;
      p0_reqack   = in_req & ~grant_id & bus_reqack;
      p1_reqack   = in_req &  grant_id & bus_reqack;

      bus_respack = in_resp & g_respack;
      p0_respcyc  = in_resp & ~grant_id & bus_respcyc;
      p1_respcyc  = in_resp &  grant_id & bus_respcyc;
      p0_resp     = (in_resp && !grant_id) ? bus_resp : '0;
      p1_resp     = (in_resp &&  grant_id) ? bus_resp : '0;

      req_beat    = bus_reqcyc & bus_reqack;
      resp_beat   = in_resp & bus_respcyc & bus_respack;
      req_last    = is_write ? (count == REQ_LAST_WR) : (count == '0);
      resp_last   = is_write ? 1'b1 : (count == RESP_LAST_RD);
      busy        = (state != IDLE);
   end

   // Transaction FSM: grant in IDLE, count request beats in REQ, count response beats in RESP.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state      <= IDLE;
         grant_id   <= 1'b0;
         last_grant <= 1'b1;
         count      <= '0;
         is_write   <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (any_req) begin
                  grant_id   <= winner;
                  last_grant <= winner;
                  is_write   <= win_write;
                  count      <= '0;
                  state      <= REQ;
               end
            end
            REQ: begin
               if (req_beat) begin
                  if (req_last) begin
                     count <= '0;
                     state <= RESP;
                  end else begin
                     count <= count + CNT_W'(1);
                  end
               end
            end
            RESP: begin
               if (resp_beat) begin
                  if (resp_last) begin
                     count <= '0;
                     state <= IDLE;
                  end else begin
                     count <= count + CNT_W'(1);
                  end
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_core_mem_arbiter.sv
// tb_core_mem_arbiter: scoreboard bench for core_mem_arbiter. Stimulus pushes the
// expected response data and grant order; a monitor pops them as the DUT responds.
module tb_core_mem_arbiter;

   localparam int ADDR_W   = 64;
   localparam int TAG_W    = 13;
   localparam int RD_BEATS = 8;
   localparam int WR_BEATS = 8;

   logic              clk = 1'b0;
   logic              reset = 1'b0;
   logic              p0_reqcyc, p1_reqcyc;
   logic [ADDR_W-1:0] p0_req, p1_req;
   logic [0:TAG_W-1]  p0_reqtag, p1_reqtag;
   logic              p0_reqack, p1_reqack;
   logic              p0_respcyc, p1_respcyc;
   logic [ADDR_W-1:0] p0_resp, p1_resp;
   logic              p0_respack, p1_respack;
   logic              bus_reqcyc;
   logic [ADDR_W-1:0] bus_req;
   logic [0:TAG_W-1]  bus_reqtag;
   logic              bus_reqack;
   logic              bus_respcyc;
   logic [ADDR_W-1:0] bus_resp;
   logic              bus_respack;
   logic              busy;
   logic              grant_id;

   core_mem_arbiter #(
      .ADDR_W(ADDR_W), .TAG_W(TAG_W), .RD_BEATS(RD_BEATS), .WR_BEATS(WR_BEATS)
   ) dut (
      .clk(clk), .reset(reset),
      .p0_reqcyc(p0_reqcyc), .p0_req(p0_req), .p0_reqtag(p0_reqtag), .p0_reqack(p0_reqack),
      .p0_respcyc(p0_respcyc), .p0_resp(p0_resp), .p0_respack(p0_respack),
      .p1_reqcyc(p1_reqcyc), .p1_req(p1_req), .p1_reqtag(p1_reqtag), .p1_reqack(p1_reqack),
      .p1_respcyc(p1_respcyc), .p1_resp(p1_resp), .p1_respack(p1_respack),
      .bus_reqcyc(bus_reqcyc), .bus_req(bus_req), .bus_reqtag(bus_reqtag), .bus_reqack(bus_reqack),
      .bus_respcyc(bus_respcyc), .bus_resp(bus_resp), .bus_respack(bus_respack),
      .busy(busy), .grant_id(grant_id)
   );

   // Free-running clock, period 10.
   always #5 clk = ~clk;

   int                tests_run    = 0;
   int                tests_failed = 0;
   logic [ADDR_W-1:0] exp0[$];
   logic [ADDR_W-1:0] exp1[$];
   logic              exp_grant[$];
   int                resp_seen0 = 0;
   int                resp_seen1 = 0;
   int                req_beats  = 0;
   logic              prev_busy  = 1'b0;
   logic              alt_ack    = 1'b0;
   logic              stray      = 1'b0;

   task automatic check_output(input string name, input logic [ADDR_W-1:0] actual,
                               input logic [ADDR_W-1:0] expected);
      tests_run++;
      if (actual !== expected) begin
         tests_failed++;
         $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
      end
   endtask

   task automatic check_bit(input string name, input logic actual, input logic expected);
      tests_run++;
      if (actual !== expected) begin
         tests_failed++;
         $display("[TB] FAIL %s: got %0b, expected %0b", name, actual, expected);
      end
   endtask

   task automatic set_port(input int p, input logic cyc, input logic [ADDR_W-1:0] data,
                           input logic [0:TAG_W-1] tag);
      if (p == 0) begin
         p0_reqcyc = cyc;
         p0_req    = data;
         p0_reqtag = tag;
      end else begin
         p1_reqcyc = cyc;
         p1_req    = data;
         p1_reqtag = tag;
      end
   endtask

   // Issues one transaction on port p (entered and left at posedge+1) and pushes
   // the responses it must produce: addr+i per read beat, or for a write the sum
   // of its data beats wbase+1 .. wbase+WR_BEATS.
   task automatic apply_stimulus(input int p, input logic wr, input logic [ADDR_W-1:0] addr,
                                 input logic [ADDR_W-1:0] wbase);
      int                nbeats;
      int                b   = 0;
      int                cyc = 0;
      logic [0:TAG_W-1]  tag;
      logic [ADDR_W-1:0] beat;
      logic [ADDR_W-1:0] wexp;
      nbeats = wr ? 1 + WR_BEATS : 1;
      tag = '0;
      tag[0] = wr;
      tag[TAG_W-1] = 1'(p);
      if (wr) begin
         wexp = wbase * ADDR_W'(WR_BEATS) + ADDR_W'(WR_BEATS * (WR_BEATS + 1) / 2);
         if (p == 0) exp0.push_back(wexp);
         else        exp1.push_back(wexp);
      end else begin
         for (int i = 0; i < RD_BEATS; i++) begin
            if (p == 0) exp0.push_back(addr + ADDR_W'(i));
            else        exp1.push_back(addr + ADDR_W'(i));
         end
      end
      while (b < nbeats && cyc < 300) begin
         beat = (b == 0) ? addr : wbase + ADDR_W'(b);
         set_port(p, 1'b1, beat, tag);
         @(negedge clk);
         if ((p == 0) ? p0_reqack : p1_reqack) b++;
         @(posedge clk);
         #1;
         cyc++;
      end
      set_port(p, 1'b0, '0, '0);
      check_output($sformatf("p%0d_req_beats", p), ADDR_W'(b), ADDR_W'(nbeats));
   endtask

   // Waits (bounded) until every pushed expectation has been consumed and the arbiter is idle.
   task automatic wait_done(input string name);
      int cyc = 0;
      do begin
         @(negedge clk);
         #1;
         cyc++;
      end while ((busy || exp0.size() != 0 || exp1.size() != 0 || exp_grant.size() != 0) && cyc < 400);
      check_output({name, "_pending"}, ADDR_W'(exp0.size() + exp1.size() + exp_grant.size()), '0);
      check_bit({name, "_busy"}, busy, 1'b0);
      @(posedge clk);
      #1;
   endtask

   // Downstream bus model: acks request beats, then returns addr+i per read beat
   // or the sum of the write data beats as the single write response.
   initial begin : responder
      int                beats_in  = 0;
      int                resp_left = 0;
      int                resp_idx  = 0;
      logic              wr        = 1'b0;
      logic              tog       = 1'b0;
      logic [ADDR_W-1:0] addr      = '0;
      logic [ADDR_W-1:0] wsum      = '0;
      bus_reqack  = 1'b0;
      bus_respcyc = 1'b0;
      bus_resp    = '0;
      forever begin
         @(negedge clk);
         if (!reset) begin
            beats_in  = 0;
            resp_left = 0;
            resp_idx  = 0;
         end else if (bus_reqcyc && bus_reqack) begin
            if (beats_in == 0) begin
               addr = bus_req;
               wr   = bus_reqtag[0];
               wsum = '0;
            end else begin
               wsum = wsum + bus_req;
            end
            beats_in++;
            if (beats_in == (wr ? 1 + WR_BEATS : 1)) begin
               beats_in  = 0;
               resp_left = wr ? 1 : RD_BEATS;
               resp_idx  = 0;
            end
         end else if (bus_respcyc && bus_respack && resp_left > 0) begin
            resp_left--;
            resp_idx++;
         end
         @(posedge clk);
         #1;
         tog         = ~tog;
         bus_reqack  = alt_ack ? tog : 1'b1;
         bus_respcyc = stray || (resp_left > 0);
         bus_resp    = stray ? 64'hDEAD_BEEF : (wr ? wsum : addr + ADDR_W'(resp_idx));
      end
   end

   // Scoreboard monitor: compares every accepted response beat and every new grant.
   initial begin : monitor
      forever begin
         @(negedge clk);
         if (p0_respcyc && p0_respack) begin
            resp_seen0++;
            if (exp0.size() == 0) check_bit("p0_unexpected_respcyc", p0_respcyc, 1'b0);
            else                  check_output("p0_resp", p0_resp, exp0.pop_front());
         end
         if (p1_respcyc && p1_respack) begin
            resp_seen1++;
            if (exp1.size() == 0) check_bit("p1_unexpected_respcyc", p1_respcyc, 1'b0);
            else                  check_output("p1_resp", p1_resp, exp1.pop_front());
         end
         if (busy && !prev_busy) begin
            if (exp_grant.size() == 0) check_bit("unexpected_grant_busy", busy, 1'b0);
            else                       check_bit("grant_id", grant_id, exp_grant.pop_front());
         end
         prev_busy = busy;
         if (bus_reqcyc && bus_reqack) req_beats++;
      end
   end

   // Hard stop in case something never completes.
   initial begin : watchdog
      #500000;
      $display("[TB] FAIL watchdog: got no completion, expected summary before timeout");
      $fatal(1, "[TB] watchdog expired");
   end

   // Directed test sequence.
   initial begin : stimulus
      int base;
      int cyc;
      p0_reqcyc = 1'b0; p0_req = '0; p0_reqtag = '0; p0_respack = 1'b1;
      p1_reqcyc = 1'b0; p1_req = '0; p1_reqtag = '0; p1_respack = 1'b1;
      reset = 1'b0;
      repeat (3) @(posedge clk);
      #1 reset = 1'b1;
      @(negedge clk);
      check_bit("rst_busy", busy, 1'b0);
      check_bit("rst_grant_id", grant_id, 1'b0);
      check_bit("rst_bus_reqcyc", bus_reqcyc, 1'b0);
      check_bit("rst_bus_respack", bus_respack, 1'b0);
      @(posedge clk);
      #1;

      // Single p0 read: bus request appears one cycle after the port request.
      exp_grant.push_back(1'b0);
      fork
         apply_stimulus(0, 1'b0, 64'h1000, '0);
         begin
            @(negedge clk);
            check_bit("t1_bus_reqcyc_idle", bus_reqcyc, 1'b0);
            @(negedge clk);
            check_bit("t1_bus_reqcyc", bus_reqcyc, 1'b1);
            check_output("t1_bus_req", bus_req, 64'h1000);
         end
      join
      wait_done("t1");

      // Both ports from reset: p0 first (last_grant resets to 1), then p1.
      reset = 1'b0;
      repeat (2) @(posedge clk);
      #1 reset = 1'b1;
      @(posedge clk);
      #1;
      exp_grant.push_back(1'b0);
      exp_grant.push_back(1'b1);
      fork
         apply_stimulus(0, 1'b0, 64'h2000, '0);
         apply_stimulus(1, 1'b0, 64'h2100, '0);
      join
      wait_done("t2");

      // Both ports continuously for four transactions: 0,1,0,1.
      exp_grant.push_back(1'b0);
      exp_grant.push_back(1'b1);
      exp_grant.push_back(1'b0);
      exp_grant.push_back(1'b1);
      fork
         begin
            apply_stimulus(0, 1'b0, 64'h3000, '0);
            apply_stimulus(0, 1'b0, 64'h3100, '0);
         end
         begin
            apply_stimulus(1, 1'b0, 64'h3800, '0);
            apply_stimulus(1, 1'b0, 64'h3900, '0);
         end
      join
      wait_done("t3");

      // Same port back-to-back with the other idle is re-granted.
      exp_grant.push_back(1'b0);
      exp_grant.push_back(1'b0);
      apply_stimulus(0, 1'b0, 64'h4000, '0);
      apply_stimulus(0, 1'b0, 64'h4400, '0);
      wait_done("t4");

      // p1 write with bus_reqack every other cycle: 9 request beats, 1 response beat.
      alt_ack = 1'b1;
      @(posedge clk);
      #1;
      base = req_beats;
      exp_grant.push_back(1'b1);
      apply_stimulus(1, 1'b1, 64'h5000, 64'h5100);
      wait_done("t5");
      check_output("t5_bus_req_beats", ADDR_W'(req_beats - base), ADDR_W'(1 + WR_BEATS));
      alt_ack = 1'b0;

      // Stray bus response while idle is neither acked nor forwarded.
      stray = 1'b1;
      @(posedge clk);
      #1;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check_bit("t6_stray_bus_respack", bus_respack, 1'b0);
         check_bit("t6_stray_p0_respcyc", p0_respcyc, 1'b0);
         check_bit("t6_stray_p1_respcyc", p1_respcyc, 1'b0);
      end
      @(posedge clk);
      #1 stray = 1'b0;
      repeat (2) @(posedge clk);
      #1;

      // Asynchronous reset in the middle of a read's response phase.
      base = resp_seen0;
      exp_grant.push_back(1'b0);
      apply_stimulus(0, 1'b0, 64'h6000, '0);
      cyc = 0;
      while (resp_seen0 < base + 3 && cyc < 100) begin
         @(negedge clk);
         #1;
         cyc++;
      end
      check_output("t7_beats_before_reset", ADDR_W'(resp_seen0 - base), ADDR_W'(3));
      @(posedge clk);
      #2 reset = 1'b0;
      #1;
      check_bit("t7_rst_busy", busy, 1'b0);
      check_bit("t7_rst_grant_id", grant_id, 1'b0);
      check_bit("t7_rst_p0_respcyc", p0_respcyc, 1'b0);
      check_output("t7_rst_p0_resp", p0_resp, '0);
      check_bit("t7_rst_p1_respcyc", p1_respcyc, 1'b0);
      check_bit("t7_rst_bus_respack", bus_respack, 1'b0);
      check_bit("t7_rst_bus_reqcyc", bus_reqcyc, 1'b0);
      check_bit("t7_rst_p0_reqack", p0_reqack, 1'b0);
      exp0.delete();
      exp_grant.delete();
      repeat (2) @(posedge clk);
      #1 reset = 1'b1;
      @(negedge clk);
      check_bit("t7_post_rst_busy", busy, 1'b0);
      @(posedge clk);
      #1;
      exp_grant.push_back(1'b1);
      apply_stimulus(1, 1'b0, 64'h7000, '0);
      wait_done("t7");

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
